// File: rtl/apb_slave.sv
// apb_slave: APB completer with 16x32 register bank, configurable wait states and error response
module apb_slave #(
  parameter int WAIT_STATES = 0
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t      state;
  logic [2:0]  cnt;
  logic [31:0] regs [16];
  logic        in_acc, err;
  logic [3:0]  idx;
  // ACCESS is only honoured right after SETUP or a still-waiting ACCESS
  always_comb begin
    in_acc  = PSEL && PENABLE && (state == SETUP || state == ACCESS);
    err     = |PADDR[1:0] || |PADDR[31:6];
    idx     = PADDR[5:2];
    PREADY  = in_acc && cnt == 3'(WAIT_STATES);
    PSLVERR = PREADY && err;
    PRDATA  = (PREADY && !PWRITE && !err) ? regs[idx] : 32'd0;
  end
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
      cnt   <= 3'd0;
      for (int i = 0; i < 16; i++) regs[i] <= 32'd0;
    end else begin
      state <= !PSEL ? IDLE : !PENABLE ? SETUP : (in_acc && !PREADY) ? ACCESS : IDLE;
      cnt   <= (in_acc && !PREADY) ? cnt + 3'd1 : 3'd0;
      if (PREADY && PWRITE && !err) regs[idx] <= PWDATA;
    end
  end
endmodule

// File: tb/tb_apb_slave.sv
// tb_apb_slave: directed checks of apb_slave with zero and three wait states
module tb_apb_slave;
  logic        clk = 0;
  logic        rst_n;
  logic        psel [2];
  logic        pen [2];
  logic        pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata [2];
  logic        pready [2];
  logic        pslverr [2];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  apb_slave #(.WAIT_STATES(0)) u0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(pen[0]), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
  );
  apb_slave #(.WAIT_STATES(3)) u1 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(pen[1]), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
  );

  typedef struct {
    bit          w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } vec_t;
  vec_t vec [10];

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask

  task automatic idle();
    @(posedge clk) #1;
    psel = '{0, 0};
    pen  = '{0, 0};
  endtask

  // one full transfer on DUT d, starting right after the next rising edge
  task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] er, input bit ee, input string n);
    int ws = d ? 3 : 0;
    @(posedge clk) #1;
    psel[d] = 1; pen[d] = 0; pwrite = w; paddr = a; pwdata = wd;
    @(negedge clk) check($sformatf("%s setup_ready", n), 32'(pready[d]), 32'd0);
    @(posedge clk) #1;
    pen[d] = 1;
    for (int k = 0; k <= ws; k++) begin
      @(negedge clk) check($sformatf("%s ready_c%0d", n, k), 32'(pready[d]), 32'(k == ws));
      if (k < ws) @(posedge clk);
    end
    check($sformatf("%s rdata", n), prdata[d], er);
    check($sformatf("%s slverr", n), 32'(pslverr[d]), 32'(ee));
  endtask

  initial begin
    vec[0] = '{1, 32'h04, 32'hDEADBEEF, 32'h0, 0};
    vec[1] = '{1, 32'h3C, 32'h12345678, 32'h0, 0};
    vec[2] = '{0, 32'h04, 32'h0, 32'hDEADBEEF, 0};
    vec[3] = '{0, 32'h3C, 32'h0, 32'h12345678, 0};
    vec[4] = '{1, 32'h40, 32'h11111111, 32'h0, 1};
    vec[5] = '{0, 32'h00, 32'h0, 32'h0, 0};
    vec[6] = '{0, 32'h06, 32'h0, 32'h0, 1};
    vec[7] = '{1, 32'h06, 32'h22222222, 32'h0, 1};
    vec[8] = '{0, 32'h04, 32'h0, 32'hDEADBEEF, 0};
    vec[9] = '{0, 32'h100, 32'h0, 32'h0, 1};
    rst_n = 0; psel = '{0, 0}; pen = '{0, 0}; pwrite = 0; paddr = 0; pwdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst%0d prdata", d), prdata[d], 32'd0);
      check($sformatf("rst%0d pready", d), 32'(pready[d]), 32'd0);
      check($sformatf("rst%0d pslverr", d), 32'(pslverr[d]), 32'd0);
    end
    @(posedge clk) #1 rst_n = 1;
    for (int i = 0; i < 16; i++) xfer(0, 0, 32'(4 * i), 0, 32'd0, 0, $sformatf("rstrd%0d", i));
    idle();
    for (int i = 0; i < 10; i++) begin
      xfer(0, vec[i].w, vec[i].addr, vec[i].wdata, vec[i].rdata, vec[i].err, $sformatf("vec%0d", i));
      idle();
    end
    xfer(1, 1, 32'h20, 32'hA5A5A5A5, 32'd0, 0, "ws_wr");
    xfer(1, 0, 32'h20, 0, 32'hA5A5A5A5, 0, "ws_rd");
    idle();
    for (int i = 0; i < 16; i++) xfer(0, 1, 32'(4 * i), 32'(i) * 32'h01010101, 32'd0, 0, $sformatf("b2bw%0d", i));
    for (int i = 0; i < 16; i++) xfer(0, 0, 32'(4 * i), 0, 32'(i) * 32'h01010101, 0, $sformatf("b2br%0d", i));
    idle();
    // ACCESS without a preceding SETUP must be ignored
    @(posedge clk) #1;
    psel[0] = 1; pen[0] = 1; pwrite = 1; paddr = 32'h10; pwdata = 32'h55;
    @(negedge clk) check("viol ready", 32'(pready[0]), 32'd0);
    idle();
    xfer(0, 0, 32'h10, 0, 32'h04040404, 0, "viol_rd");
    idle();
    // PSEL dropped during a waited ACCESS abandons the write
    @(posedge clk) #1;
    psel[1] = 1; pen[1] = 0; pwrite = 1; paddr = 32'h24; pwdata = 32'hCAFEF00D;
    @(posedge clk) #1 pen[1] = 1;
    @(negedge clk) check("drop ready", 32'(pready[1]), 32'd0);
    idle();
    xfer(1, 0, 32'h24, 0, 32'd0, 0, "drop_rd");
    xfer(1, 1, 32'h28, 32'h13572468, 32'd0, 0, "drop_wr2");
    xfer(1, 0, 32'h28, 0, 32'h13572468, 0, "drop_rd2");
    idle();
    // reset during ACCESS aborts the write
    @(posedge clk) #1;
    psel[0] = 1; pen[0] = 0; pwrite = 1; paddr = 32'h08; pwdata = 32'hFFFFFFFF;
    @(posedge clk) #1 pen[0] = 1;
    #1 rst_n = 0;
    @(negedge clk) check("abort ready", 32'(pready[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    psel = '{0, 0}; pen = '{0, 0};
    idle();
    xfer(0, 0, 32'h08, 0, 32'd0, 0, "abort_rd");
    xfer(0, 0, 32'h3C, 0, 32'd0, 0, "abort_rd3c");
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_slave.md
# apb_slave

Memory-mapped APB (AMBA 3 style) completer with a bank of 16 × 32-bit read/write registers, an optional configurable wait-state insertion and error response for illegal addresses. It sits on the peripheral bus behind an APB bridge and serves as the register block for a peripheral. It is also the reference completer for bus-level verification.

## Interface
- `WAIT_STATES`, default 0: number of extra ACCESS cycles before `PREADY` asserts; legal range 0–7.
- `PCLK` input 1: bus clock; all state updates on its rising edge.
- `PRESETn` input 1: reset, asynchronous and active-low.
- `PSEL` input 1: completer select.
- `PENABLE` input 1: marks the ACCESS phase.
- `PWRITE` input 1: 1 = write, 0 = read.
- `PADDR` input 32: byte address.
- `PWDATA` input 32: write data.
- `PRDATA` output 32: read data, valid when `PREADY`=1 on a read.
- `PREADY` output 1: transfer completes in the current cycle.
- `PSLVERR` output 1: error response, valid only when `PREADY`=1.

## Operation
- Register map: `REG[i]` at byte address 4·i, i = 0..15, covering 0x00–0x3C. All registers are R/W. Index = `PADDR[5:2]`.
- Error address: `PADDR[1:0]` != 0 (misaligned) or `PADDR[31:6]` != 0 (out of range).
- Phases:
  - SETUP: `PSEL`=1, `PENABLE`=0.
  - ACCESS: `PSEL`=1, `PENABLE`=1.
  - IDLE: `PSEL`=0.
- State machine with states IDLE, SETUP and ACCESS:
  - IDLE→SETUP on `PSEL`.
  - SETUP→ACCESS on `PSEL`&`PENABLE`.
  - ACCESS→IDLE when `PREADY`=1 and `PSEL`=0 next; ACCESS→SETUP when `PSEL`=1 and `PENABLE`=0.
  - Any state→IDLE when `PSEL`=0.
- An ACCESS cycle that does not directly follow a SETUP or ACCESS cycle is a protocol violation. It is ignored: `PREADY`=0, no register update.
- Wait counter (3 bits):
  - Clears on entry to SETUP.
  - Increments each ACCESS cycle while `PREADY`=0.
- `PREADY` = (state ACCESS) & (wait counter == `WAIT_STATES`). It is combinational from state, counter and `PSEL`/`PENABLE`.
- Write commit: at the rising edge where `PREADY`=1, `PWRITE`=1 and the address is legal, `REG[idx]` ← `PWDATA`.
- Reads: when `PREADY`=1, `PWRITE`=0 and the address is legal, `PRDATA` = `REG[idx]`. At all other times `PRDATA` = 0.
- `PSLVERR` = `PREADY` & error address, for both reads and writes. An erroring write modifies no register; an erroring read returns `PRDATA`=0.
- `PWRITE`, `PADDR` and `PWDATA` are sampled in the completing cycle. The requester holds them stable through SETUP and ACCESS.

## Timing
- Reset values: all `REG` = 0, state IDLE, wait counter 0, `PREADY`=0, `PSLVERR`=0, `PRDATA`=0. Reset takes effect immediately on `PRESETn` falling, independent of `PCLK`.
- Reset asserted mid-transfer: the transfer is aborted and no write commits. After deassertion the block waits in IDLE for a fresh SETUP.
- Transfer length is 2 + `WAIT_STATES` cycles (SETUP + ACCESS cycles). With `WAIT_STATES`=0, `PREADY` is high in the first ACCESS cycle.
- Back-to-back transfers: a SETUP may immediately follow a completing ACCESS with no IDLE cycle, giving full throughput of one transfer per 2 + `WAIT_STATES` cycles.
- Write then read of the same address on consecutive transfers returns the new value.
- If `PSEL` drops during a waited ACCESS, the transfer is abandoned: no commit and the counter clears.

## Test plan
- Reset: hold `PRESETn`=0 for 3 cycles, then release. All outputs read 0, and reads of 0x00–0x3C return 0x00000000 with `PSLVERR`=0.
- Write/read: write 0xDEADBEEF to 0x04 and 0x12345678 to 0x3C, then read both back. Required: exact data, `PREADY` on the 2nd cycle of each transfer, `PSLVERR`=0.
- Error handling:
  - Write to 0x40: `PSLVERR`=1, and a subsequent read of 0x00 is unchanged.
  - Read of 0x06: `PSLVERR`=1, `PRDATA`=0.
- Wait states: build with `WAIT_STATES`=3 and write/read 0xA5A5A5A5 at 0x20. `PREADY` must stay low for 3 ACCESS cycles and rise on the 4th.
- Back-to-back: perform 16 consecutive writes of i·0x01010101 with no IDLE cycles, then 16 reads. Each read returns its value.
- Abort: assert `PRESETn`=0 during the ACCESS of a write of 0xFFFFFFFF to 0x08. The subsequent read returns 0.
